// File: rtl/word_align_lock.sv
// word_align_lock: finds, verifies and tracks a W-bit sync word at any bit offset.
// Optional WORD_ALIGN_LOCK_SYNC_DROP_EN removes sync words from the output stream.
module word_align_lock #(
  parameter int          W        = 64,
  parameter logic [63:0] SYNC     = 64'hF731_8CEF_137F_FEC8,
  parameter int          PERIOD   = 16,
  parameter int          LOCK_CNT = 2,
  parameter int          MISS_CNT = 3
) (
  input  logic                 RSTX,
  input  logic                 CLK,
  input  logic                 PHY_INIT,
  input  logic                 DIPUSH,
  input  logic [W-1:0]         DIN,
  output logic                 DOPUSH,
  output logic [W-1:0]         DOUT,
  output logic                 SYNC_FLAG,
  output logic                 ALIGNED,
  output logic [$clog2(W)-1:0] OFFSET
);

  localparam int OW  = $clog2(W);
  localparam int WCW = $clog2(PERIOD);
  localparam int HW  = $clog2(LOCK_CNT + 1);
  localparam int MW  = $clog2(MISS_CNT + 1);

  localparam logic [W-1:0]   SW     = SYNC[W-1:0];
  localparam logic [WCW-1:0] WCLAST = WCW'(PERIOD - 1);
  localparam logic [HW-1:0]  HLAST  = HW'(LOCK_CNT);
  localparam logic [MW-1:0]  MLAST  = MW'(MISS_CNT - 1);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t         state, state_n;
  logic [2*W-2:0] sh;
  logic           v;
  logic [WCW-1:0] wc, wc_n;
  logic [HW-1:0]  hits, hits_n;
  logic [MW-1:0]  misses, miss_n;
  logic [OW-1:0]  off_n;

  logic [W-1:0]   cmp;
  logic           hit_any;
  logic [OW-1:0]  hit_idx;
  logic           hit_sel;
  logic           slot;
  logic [W-1:0]   aligned;
  logic           push_c;
  logic           flag_c;

  always_comb begin
    for (int i = 0; i < W; i++) begin
      cmp[i] = (sh[i +: W] == SW);
    end
  end

  // Scan high to low so the lowest matching offset wins.
  always_comb begin
    hit_any = |cmp;
    hit_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (cmp[i]) hit_idx = OW'(i);
    end
  end

  assign hit_sel = cmp[OFFSET];
  assign slot    = v && (wc == WCLAST);
  assign aligned = sh[OFFSET +: W];
  assign ALIGNED = (state == LOCKED);

  always_comb begin
    state_n = state;
    off_n   = OFFSET;
    wc_n    = wc;
    hits_n  = hits;
    miss_n  = misses;
    if (v) wc_n = slot ? '0 : wc + 1'b1;
    if (PHY_INIT) begin
      state_n = HUNT;
      off_n   = '0;
      wc_n    = '0;
      hits_n  = '0;
      miss_n  = '0;
    end else if (v) begin
      unique case (state)
        HUNT: begin
          if (hit_any) begin
            off_n   = hit_idx;
            wc_n    = '0;
            hits_n  = HW'(1);
            state_n = VERIFY;
          end
        end
        VERIFY: begin
          if (slot) begin
            if (!hit_sel) begin
              state_n = HUNT;
            end else if (hits >= HLAST) begin
              state_n = LOCKED;
              miss_n  = '0;
            end else begin
              hits_n = hits + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (slot) begin
            if (hit_sel) begin
              miss_n = '0;
            end else if (misses == MLAST) begin
              state_n = HUNT;
              off_n   = '0;
              miss_n  = '0;
            end else begin
              miss_n = misses + 1'b1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_comb begin
    flag_c = v && (state == LOCKED) && !PHY_INIT
             && slot && hit_sel;
`ifdef WORD_ALIGN_LOCK_SYNC_DROP_EN
    push_c = v && (state == LOCKED) && !PHY_INIT
             && !flag_c;
`else
    push_c = v && (state == LOCKED) && !PHY_INIT;
`endif
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      sh        <= '0;
      v         <= 1'b0;
      state     <= HUNT;
      OFFSET    <= '0;
      wc        <= '0;
      hits      <= '0;
      misses    <= '0;
      DOPUSH    <= 1'b0;
      DOUT      <= '0;
      SYNC_FLAG <= 1'b0;
    end else begin
      if (DIPUSH) sh <= {sh[W-2:0], DIN};
      v      <= DIPUSH;
      state  <= state_n;
      OFFSET <= off_n;
      wc     <= wc_n;
      hits   <= hits_n;
      misses <= miss_n;
      DOPUSH <= push_c;
      if (push_c) DOUT <= aligned;
`ifdef WORD_ALIGN_LOCK_SYNC_DROP_EN
      SYNC_FLAG <= 1'b0;
`else
      SYNC_FLAG <= flag_c;
`endif
    end
  end

endmodule

// File: tb/tb_word_align_lock.sv
// tb_word_align_lock: directed table and hand sequences for word_align_lock.
// Second instance (W=32, 15-periodic sync) covers two matches in one window.
module tb_word_align_lock;

  localparam int W = 64;
  localparam logic [W-1:0] SYNC = 64'hF731_8CEF_137F_FEC8;
  localparam logic [14:0] P15 = 15'h2B4D;
  localparam logic [31:0] SYNC32 = {P15[1:0], P15, P15};
`ifdef WORD_ALIGN_LOCK_SYNC_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RSTX = 1'b0;
  logic         PHY_INIT = 1'b0;
  logic         DIPUSH = 1'b0;
  logic [W-1:0] DIN = '0;
  logic         DOPUSH;
  logic [W-1:0] DOUT;
  logic         SYNC_FLAG;
  logic         ALIGNED;
  logic [5:0]   OFFSET;

  logic         DIPUSH2 = 1'b0;
  logic         PHY_INIT2 = 1'b0;
  logic [31:0]  DIN2 = '0;
  logic         DOPUSH2;
  logic [31:0]  DOUT2;
  logic         SYNC_FLAG2;
  logic         ALIGNED2;
  logic [4:0]   OFFSET2;

  word_align_lock dut (
    .RSTX(RSTX), .CLK(CLK), .PHY_INIT(PHY_INIT),
    .DIPUSH(DIPUSH), .DIN(DIN), .DOPUSH(DOPUSH),
    .DOUT(DOUT), .SYNC_FLAG(SYNC_FLAG),
    .ALIGNED(ALIGNED), .OFFSET(OFFSET)
  );

  word_align_lock #(.W(32), .SYNC({32'd0, SYNC32})) dut2 (
    .RSTX(RSTX), .CLK(CLK), .PHY_INIT(PHY_INIT2),
    .DIPUSH(DIPUSH2), .DIN(DIN2), .DOPUSH(DOPUSH2),
    .DOUT(DOUT2), .SYNC_FLAG(SYNC_FLAG2),
    .ALIGNED(ALIGNED2), .OFFSET(OFFSET2)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_S, K_F, K_X} kind_t;
  typedef struct {
    logic [W-1:0] w;
    bit al;
    int of;
    bit dp;
    bit sf;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] aq[$];
  int           oq[$];
  int           npass = 0;
  int           ntot = 0;
  logic [W-1:0] expd;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic logic [W-1:0] rawof(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input int off);
    logic [2*W-1:0] t;
    t = {a, b} << off;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] fill();
    return {$urandom, $urandom};
  endfunction

  task automatic qw(input logic [W-1:0] w, input int off);
    aq.push_back(w);
    oq.push_back(off);
  endtask

  task automatic qper(input logic [W-1:0] w, input int off);
    qw(w, off);
    for (int j = 0; j < 15; j++) qw(fill(), off);
  endtask

  task automatic add(input kind_t k, input int off,
                     input bit al, input int of,
                     input bit dp, input bit sf);
    vec_t r;
    logic [W-1:0] w;
    w = (k == K_S) ? SYNC : (k == K_X) ? ~SYNC : fill();
    if (DROP && k == K_S && sf) dp = 1'b0;
    if (DROP) sf = 1'b0;
    r.w = w; r.al = al; r.of = of; r.dp = dp; r.sf = sf;
    tbl.push_back(r);
    qw(w, off);
  endtask

  task automatic add_per(input kind_t k, input int off,
                         input bit al, input int of,
                         input bit dp, input bit sf,
                         input int foff, input bit fal,
                         input int fof, input bit fdp);
    add(k, off, al, of, dp, sf);
    for (int j = 0; j < 15; j++)
      add(K_F, foff, fal, fof, fdp, 1'b0);
  endtask

  // One word event, then an idle cycle; outputs settle two edges later.
  task automatic step(input bit pi);
    @(negedge CLK);
    DIN = rawof(aq[0], aq[1], oq[0]);
    DIPUSH = 1'b1;
    PHY_INIT = pi;
    void'(aq.pop_front());
    void'(oq.pop_front());
    @(negedge CLK);
    DIPUSH = 1'b0;
    PHY_INIT = 1'b0;
    @(negedge CLK);
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step(1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTX = 1'b0;
    aq.delete();
    oq.delete();
    repeat (2) @(negedge CLK);
    RSTX = 1'b1;
  endtask

  initial begin
    int p6;
    int npush;
    logic [62:0] x;

    add(K_F, 13, 0, 0, 0, 0);
    add_per(K_S, 13, 0, 13, 0, 0, 13, 0, 13, 0);
    add_per(K_S, 13, 0, 13, 0, 0, 13, 0, 13, 0);
    add_per(K_S, 13, 1, 13, 0, 0, 13, 1, 13, 1);
    add_per(K_X, 13, 1, 13, 1, 0, 13, 1, 13, 1);
    add_per(K_X, 13, 1, 13, 1, 0, 13, 1, 13, 1);
    p6 = tbl.size();
    add_per(K_S, 13, 1, 13, 1, 1, 13, 1, 13, 1);
    add_per(K_X, 13, 1, 13, 1, 0, 13, 1, 13, 1);
    add_per(K_X, 13, 1, 13, 1, 0, 13, 1, 13, 1);
    add_per(K_X, 13, 0, 0, 1, 0, 40, 0, 0, 0);
    add_per(K_S, 40, 0, 40, 0, 0, 40, 0, 40, 0);
    add_per(K_S, 40, 0, 40, 0, 0, 40, 0, 40, 0);
    add(K_S, 40, 1, 40, 0, 0);
    add(K_F, 40, 1, 40, 1, 0);
    qw(fill(), 40);

    repeat (3) @(negedge CLK);
    chk("rst_dopush", 64'(DOPUSH), 64'd0);
    chk("rst_dout", 64'(DOUT), 64'd0);
    chk("rst_sync_flag", 64'(SYNC_FLAG), 64'd0);
    chk("rst_aligned", 64'(ALIGNED), 64'd0);
    chk("rst_offset", 64'(OFFSET), 64'd0);
    RSTX = 1'b1;

    // Two sync matches (offsets 5 and 20) in one window of dut2.
    x = ({31'd0, SYNC32} << 5) | ({31'd0, SYNC32} << 20);
    @(negedge CLK);
    DIN2 = {1'b0, x[62:32]};
    DIPUSH2 = 1'b1;
    @(negedge CLK);
    DIN2 = x[31:0];
    @(negedge CLK);
    DIPUSH2 = 1'b0;
    @(negedge CLK);
    chk("dual_offset", 64'(OFFSET2), 64'd5);
    chk("dual_aligned", 64'(ALIGNED2), 64'd0);

    expd = '0;
    npush = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0);
      if (tbl[i].dp) expd = tbl[i].w;
      chk($sformatf("v%0d_aligned", i),
          64'(ALIGNED), 64'(tbl[i].al));
      chk($sformatf("v%0d_offset", i),
          64'(OFFSET), 64'(tbl[i].of));
      chk($sformatf("v%0d_dopush", i),
          64'(DOPUSH), 64'(tbl[i].dp));
      chk($sformatf("v%0d_sync_flag", i),
          64'(SYNC_FLAG), 64'(tbl[i].sf));
      chk($sformatf("v%0d_dout", i), DOUT, expd);
      if (i >= p6 && i < p6 + 16) npush += int'(DOPUSH);
    end
    chk("period_push_count", 64'(npush),
        DROP ? 64'd15 : 64'd16);

    // Asynchronous reset while locked and pushing.
    @(posedge CLK);
    #2;
    RSTX = 1'b0;
    #1;
    chk("arst_aligned", 64'(ALIGNED), 64'd0);
    chk("arst_offset", 64'(OFFSET), 64'd0);
    chk("arst_dout", 64'(DOUT), 64'd0);
    chk("arst_dopush", 64'(DOPUSH), 64'd0);
    chk("arst_sync_flag", 64'(SYNC_FLAG), 64'd0);
    do_reset();

    // Second sync one word late while verifying.
    qw(fill(), 7);
    qper(SYNC, 7);
    qw(fill(), 7);
    qper(SYNC, 7);
    qper(SYNC, 7);
    qw(SYNC, 7);
    qw(fill(), 7);
    qw(fill(), 7);
    steps(2);
    chk("late_first_offset", 64'(OFFSET), 64'd7);
    steps(16);
    chk("late_miss_aligned", 64'(ALIGNED), 64'd0);
    steps(1);
    chk("late_restart_offset", 64'(OFFSET), 64'd7);
    steps(16);
    chk("late_2nd_aligned", 64'(ALIGNED), 64'd0);
    steps(15);
    chk("late_pre3_aligned", 64'(ALIGNED), 64'd0);
    steps(1);
    chk("late_lock_aligned", 64'(ALIGNED), 64'd1);
    steps(1);
    chk("late_lock_dopush", 64'(DOPUSH), 64'd1);
    do_reset();

    // PHY_INIT coincident with DIPUSH while locked.
    qw(fill(), 13);
    qper(SYNC, 13);
    qper(SYNC, 13);
    qw(SYNC, 13);
    for (int j = 0; j < 16; j++) qw(fill(), 13);
    qper(SYNC, 13);
    qper(SYNC, 13);
    qw(SYNC, 13);
    qw(fill(), 13);
    qw(fill(), 13);
    steps(34);
    chk("pi_pre_aligned", 64'(ALIGNED), 64'd1);
    @(negedge CLK);
    DIN = rawof(aq[0], aq[1], 13);
    DIPUSH = 1'b1;
    void'(aq.pop_front());
    void'(oq.pop_front());
    @(negedge CLK);
    DIN = rawof(aq[0], aq[1], 13);
    PHY_INIT = 1'b1;
    void'(aq.pop_front());
    void'(oq.pop_front());
    @(negedge CLK);
    DIPUSH = 1'b0;
    PHY_INIT = 1'b0;
    chk("pi_aligned", 64'(ALIGNED), 64'd0);
    chk("pi_dopush", 64'(DOPUSH), 64'd0);
    chk("pi_offset", 64'(OFFSET), 64'd0);
    @(negedge CLK);
    chk("pi_next_dopush", 64'(DOPUSH), 64'd0);
    steps(15);
    chk("pi_relock1_offset", 64'(OFFSET), 64'd13);
    chk("pi_relock1_aligned", 64'(ALIGNED), 64'd0);
    steps(16);
    chk("pi_relock2_aligned", 64'(ALIGNED), 64'd0);
    steps(16);
    chk("pi_relock3_aligned", 64'(ALIGNED), 64'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
